// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate modes, registered
// terminal-count pulse and zero flag. Optional sticky overflow flag under `UDC_OVF_FLAG_EN.
module updown_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_cnt,
  input  logic             updn_cnt,
  input  logic             count_enb,
  input  logic             sat_mode,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             zero,
  output logic             ovf_flag
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_boundary;

  assign w_at_max   = (r_count == C_MAX);
  assign w_at_zero  = (r_count == '0);
  // A boundary event is a requested step that would leave the [0, MAX_VAL] range.
  assign w_boundary = !ld_cnt && count_enb && (updn_cnt ? w_at_max : w_at_zero);

  // Next-state never exceeds MAX_VAL: increments only happen below MAX_VAL and
  // out-of-range loads are clipped before reaching the register.
  always_comb begin
    w_count_nxt = r_count;
    if (ld_cnt) begin
      w_count_nxt = (data_in > C_MAX) ? C_MAX : data_in;
    end else if (count_enb) begin
      if (updn_cnt) begin
        if (w_at_max) w_count_nxt = sat_mode ? C_MAX : '0;
        else          w_count_nxt = r_count + 1'b1;
      end else begin
        if (w_at_zero) w_count_nxt = sat_mode ? '0 : C_MAX;
        else           w_count_nxt = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_boundary;
    end
  end

  assign data_out = r_count;
  assign tc       = r_tc;
  assign zero     = (r_count == '0);

`ifdef UDC_OVF_FLAG_EN
  logic r_ovf;

  // Clear wins over a same-cycle boundary event; loads leave the flag alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_ovf <= 1'b0;
    else if (ovf_clr)    r_ovf <= 1'b0;
    else if (w_boundary) r_ovf <= 1'b1;
  end

  assign ovf_flag = r_ovf;
`else
  logic w_unused_ovf_clr;

  assign w_unused_ovf_clr = ovf_clr;
  assign ovf_flag         = 1'b0;
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod (WIDTH=4, MAX_VAL=9): directed scenarios
// plus randomized stimulus against an arithmetic reference model.
module tb_updown_counter_mod;

  localparam int WIDTH   = 4;
  localparam int MAX_VAL = 9;
  localparam int VW      = WIDTH + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             ld_cnt;
  logic             updn_cnt;
  logic             count_enb;
  logic             sat_mode;
  logic             ovf_clr;
  logic [WIDTH-1:0] data_out;
  logic             tc;
  logic             zero;
  logic             ovf_flag;

  int checks = 0;
  int errors = 0;

  // Expected {ovf_flag, zero, tc, data_out} after each driven cycle
  logic [VW-1:0] exp_q[$];

  int m_count;
  bit m_tc;
  bit m_ovf;

  updown_counter_mod #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .ld_cnt   (ld_cnt),
    .updn_cnt (updn_cnt),
    .count_enb(count_enb),
    .sat_mode (sat_mode),
    .ovf_clr  (ovf_clr),
    .data_out (data_out),
    .tc       (tc),
    .zero     (zero),
    .ovf_flag (ovf_flag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic model_reset();
    m_count = 0;
    m_tc    = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of controls at the falling edge, advances the model, and
  // returns at the next falling edge with the expected outputs queued.
  task automatic drive_cycle(input bit ld, input int din, input bit up, input bit en,
                             input bit sat, input bit clr);
    bit bnd;
    ld_cnt    = ld;
    data_in   = WIDTH'(din);
    updn_cnt  = up;
    count_enb = en;
    sat_mode  = sat;
    ovf_clr   = clr;
    bnd = !ld && en && ((up && m_count == MAX_VAL) || (!up && m_count == 0));
    if (ld) begin
      m_count = (din > MAX_VAL) ? MAX_VAL : din;
    end else if (en) begin
      if (up) m_count = sat ? ((m_count + 1 > MAX_VAL) ? MAX_VAL : m_count + 1)
                            : (m_count + 1) % (MAX_VAL + 1);
      else    m_count = sat ? ((m_count == 0) ? 0 : m_count - 1)
                            : (m_count + MAX_VAL) % (MAX_VAL + 1);
    end
    m_tc = bnd;
`ifdef UDC_OVF_FLAG_EN
    if (clr)      m_ovf = 1'b0;
    else if (bnd) m_ovf = 1'b1;
`else
    m_ovf = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back({m_ovf, (m_count == 0), m_tc, WIDTH'(m_count)});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; data_in = '0; ld_cnt = 0; updn_cnt = 0; count_enb = 0; sat_mode = 0; ovf_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ovf_flag, zero, tc, data_out} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state got ovf=%0b zero=%0b tc=%0b cnt=%0d want 0 1 0 0",
               ovf_flag, zero, tc, data_out);
    end
    rst = 1'b0;
    drive_cycle(1, 5, 0, 0, 0, 0);
    checks++;
    if (data_out !== 4'd5 || zero !== 1'b0) begin
      errors++;
      $display("FAIL load5 got cnt=%0d zero=%0b want 5 0", data_out, zero);
    end
    // Async reset mid-cycle, far from any clock edge
    #2 rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 4'd0 || zero !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d zero=%0b tc=%0b want 0 1 0", data_out, zero, tc);
    end
    @(negedge clk) rst = 1'b0;
    model_reset();
    // A pending tc is dropped by reset
    drive_cycle(1, 9, 1, 0, 1, 0);
    drive_cycle(0, 0, 1, 1, 1, 0);
    checks++;
    if (tc !== 1'b1 || data_out !== 4'd9) begin
      errors++;
      $display("FAIL tc_before_reset got tc=%0b cnt=%0d want 1 9", tc, data_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b0 || data_out !== 4'd0 || ovf_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_tc got tc=%0b cnt=%0d ovf=%0b want 0 0 0", tc, data_out, ovf_flag);
    end
    @(negedge clk) rst = 1'b0;
    model_reset();
  endtask

  task automatic test_wrap_up();
    int exp_cnt[3] = '{8, 9, 0};
    bit exp_tc[3]  = '{0, 0, 1};
    drive_cycle(1, 7, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 1, 1, 0, 0);
      checks++;
      if (data_out !== WIDTH'(exp_cnt[i]) || tc !== exp_tc[i]) begin
        errors++;
        $display("FAIL wrap_up[%0d] got cnt=%0d tc=%0b want %0d %0b",
                 i, data_out, tc, exp_cnt[i], exp_tc[i]);
      end
    end
    drive_cycle(0, 0, 1, 0, 0, 0);
    checks++;
    if (tc !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up_tc_pulse got tc=%0b zero=%0b want 0 1", tc, zero);
    end
  endtask

  task automatic test_sat_down();
    int exp_cnt[4] = '{1, 0, 0, 0};
    bit exp_tc[4]  = '{0, 0, 1, 1};
    drive_cycle(1, 2, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, 0, 1, 1, 0);
      checks++;
      if (data_out !== WIDTH'(exp_cnt[i]) || tc !== exp_tc[i]) begin
        errors++;
        $display("FAIL sat_down[%0d] got cnt=%0d tc=%0b want %0d %0b",
                 i, data_out, tc, exp_cnt[i], exp_tc[i]);
      end
    end
    // Wrap down from 0 lands on MAX_VAL
    drive_cycle(0, 0, 0, 1, 0, 0);
    checks++;
    if (data_out !== 4'd9 || tc !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down got cnt=%0d tc=%0b want 9 1", data_out, tc);
    end
  endtask

  task automatic test_load();
    drive_cycle(1, 14, 0, 0, 0, 0);
    checks++;
    if (data_out !== 4'd9) begin
      errors++;
      $display("FAIL load_clip got cnt=%0d want 9", data_out);
    end
    drive_cycle(1, 9, 1, 1, 0, 0);
    checks++;
    if (data_out !== 4'd9 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_over_step got cnt=%0d tc=%0b want 9 0", data_out, tc);
    end
    drive_cycle(1, 15, 1, 1, 1, 0);
    checks++;
    if (data_out !== 4'd9 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_max_code got cnt=%0d tc=%0b want 9 0", data_out, tc);
    end
  endtask

  task automatic test_hold_toggle();
    int exp_cnt[3] = '{5, 4, 5};
    drive_cycle(1, 4, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, i[0], 0, 0, 0);
      checks++;
      if (data_out !== 4'd4 || tc !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got cnt=%0d tc=%0b want 4 0", i, data_out, tc);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, (i % 2 == 0), 1, 0, 0);
      checks++;
      if (data_out !== WIDTH'(exp_cnt[i])) begin
        errors++;
        $display("FAIL toggle[%0d] got cnt=%0d want %0d", i, data_out, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_ovf_flag();
    drive_cycle(1, 9, 1, 0, 0, 1);
    drive_cycle(0, 0, 1, 1, 0, 0);
`ifdef UDC_OVF_FLAG_EN
    checks++;
    if (ovf_flag !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %0b want 1", ovf_flag);
    end
    drive_cycle(1, 9, 1, 0, 0, 0);
    checks++;
    if (ovf_flag !== 1'b1) begin
      errors++;
      $display("FAIL ovf_survives_load got %0b want 1", ovf_flag);
    end
    drive_cycle(0, 0, 1, 1, 0, 1);
    checks++;
    if (ovf_flag !== 1'b0 || data_out !== 4'd0) begin
      errors++;
      $display("FAIL ovf_clr_priority got ovf=%0b cnt=%0d want 0 0", ovf_flag, data_out);
    end
`else
    checks++;
    if (ovf_flag !== 1'b0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL ovf_disabled got ovf=%0b tc=%0b want 0 1", ovf_flag, tc);
    end
`endif
  endtask

  task automatic test_random();
    logic [VW-1:0] exp;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 15), $urandom_range(0, 1),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
      exp = exp_q.pop_front();
      checks++;
      if ({ovf_flag, zero, tc, data_out} !== exp) begin
        errors++;
        $display("FAIL random[%0d] got ovf/zero/tc/cnt=%0b/%0b/%0b/%0d want %0b/%0b/%0b/%0d",
                 i, ovf_flag, zero, tc, data_out, exp[VW-1], exp[VW-2], exp[VW-3], exp[WIDTH-1:0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load();
    test_hold_toggle();
    test_ovf_flag();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
